elastic_buffer: RTL

Parametrised successor of the two-entry skid buffer: a DEPTH-entry elastic buffer on a `ready_valid_i` stream with fully registered `in.ready`, `out.valid` and `out.data`. There is no combinational path between the two sides. It sits on long or congested datapaths, for example between the AXI4S / `ndata_i` adapters and compute stages, where more slack than two entries is needed. It also provides a synchronous flush.

---
 rtl/util_pkg.sv | 11 +
 rtl/ready_valid_i.sv | 12 +
 rtl/elastic_buffer_ctrl.sv | 66 ++++++
 rtl/elastic_buffer.sv | 63 ++++++
 4 files changed

// File: rtl/util_pkg.sv
// Shared utilities: the elastic buffer minimum depth and the occupancy-counter width helper.
package util_pkg;

    localparam int ELASTIC_BUFFER_MIN_DEPTH = 2;

    // Width of a counter that must hold every value 0..n.
    function automatic int clog2_cnt(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ready_valid_i.sv
// Generic valid/ready stream interface: m drives valid/data, s drives ready.
// A beat transfers on a rising clk edge where valid && ready; valid never waits on ready.
interface ready_valid_i #(
    parameter type data_t = logic [7:0]
);
    logic  valid;
    logic  ready;
    data_t data;

    modport m (output valid, output data, input ready);
    modport s (input valid, input data, output ready);
endinterface

// File: rtl/elastic_buffer_ctrl.sv
// Control for elastic_buffer: pointers, occupancy, registered in_ready/out_valid and flush.
// level/almost_full are built only when ELASTIC_BUFFER_LEVEL_EN is defined.
module elastic_buffer_ctrl
    import util_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = clog2_cnt(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic          out_ready,
    output logic          in_ready,
    output logic          out_valid,
    output logic          push,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr
`ifdef ELASTIC_BUFFER_LEVEL_EN
    ,
    output logic [CW-1:0] level,
    output logic          almost_full
`endif
);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(DEPTH - 1);

    logic          pop;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          almost_full_q;

    // A flush cycle cancels both handshakes, so nothing is written or consumed.
    assign push       = in_valid && in_ready && !flush;
    assign pop        = out_valid && out_ready && !flush;
    assign count_next = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count         <= count_next;
            in_ready      <= count_next < FULL_C;
            out_valid     <= count_next != '0;
            almost_full_q <= count_next >= AF_C;
        end
    end

`ifdef ELASTIC_BUFFER_LEVEL_EN
    assign level       = count;
    assign almost_full = almost_full_q;
`else
    logic unused_af;
    assign unused_af = almost_full_q;
`endif

endmodule

// File: rtl/elastic_buffer.sv
// DEPTH-entry elastic buffer with fully registered in.ready, out.valid and out.data.
// Define ELASTIC_BUFFER_LEVEL_EN to add the level and almost_full ports.
module elastic_buffer
    import util_pkg::*;
#(
    parameter type data_t = logic [7:0],
    parameter int  DEPTH  = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    flush,
    ready_valid_i.s in,
    ready_valid_i.m out
`ifdef ELASTIC_BUFFER_LEVEL_EN
    ,
    output logic [clog2_cnt(DEPTH)-1:0] level,
    output logic                        almost_full
`endif
);

    localparam int PW = $clog2(DEPTH);

    if (DEPTH < ELASTIC_BUFFER_MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("elastic_buffer: DEPTH must be a power of two and at least 2");
    end

    data_t         mem [DEPTH];
    logic          push;
    logic          in_ready;
    logic          out_valid;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    elastic_buffer_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in.valid),
        .out_ready   (out.ready),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .push        (push),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr)
`ifdef ELASTIC_BUFFER_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    // Storage is never reset; out.data is only meaningful while out.valid is high.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in.data;
    end

    assign in.ready  = in_ready;
    assign out.valid = out_valid;
    assign out.data  = mem[rd_ptr];

endmodule
